multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Parametrised multicycle control unit with memory wait-state handshake, wait timeout, fault reporting and state visibility. Sits between the instruction register opcode field and the multicycle datapath, sequencing fetch/decode/execute/memory/writeback. Successor to the fixed single-path controller: it stalls on slow memory, detects illegal opcodes and hung memory, and can optionally execute jump-and-link.

## Interface
- MEM_TIMEOUT, 16, max consecutive cycles with MemReady low in one wait state before fault; 0 disables timeout
- CNT_W, 5, wait counter width; must satisfy 2^CNT_W > MEM_TIMEOUT
- Clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state S_RST
- Op  in  6  opcode from instruction register (valid from DECODE onward)
- MemReady  in  1  memory completes current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource, ALUOp, ALUSrcB  out  2 each  datapath mux/ALU selects
- Link  out  1  write PC to register 31
- InstrDone  out  1  one-cycle pulse in last cycle of each instruction
- Fault  out  1  sticky error flag
- State  out  4  current state encoding

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, jal=000011 (macro only).
- States (encoding): S_RST 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12, JAL 13, FAULT 15.
- Outputs Moore-decoded from state; unlisted outputs 0:
  - S_RST: all 0. FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=MemReady.
  - DECODE: ALUSrcB=11. MEMADR/ADDI_EX: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1. MEMWB: RegWrite=1, MemtoReg=1. MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10. RWB: RegWrite=1, RegDst=1. ADDI_WB: RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. JUMP: PCWrite=1, PCSource=10.
  - JAL: PCWrite=1, PCSource=10, RegWrite=1, Link=1. FAULT: all 0 except Fault=1.
- Transitions: S_RST→FETCH; FETCH→DECODE on MemReady; DECODE→by opcode (lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDI_EX, jal→JAL, other→FAULT); MEMADR→MEMRD (lw) or MEMWR (sw); MEMRD→MEMWB on MemReady; MEMWR→FETCH on MemReady; EXEC→RWB; ADDI_EX→ADDI_WB; MEMWB, RWB, ADDI_WB, BRANCH, JUMP, JAL→FETCH; FAULT→FAULT.
- Wait states (FETCH, MEMRD, MEMWR) hold all outputs while MemReady=0.
- Wait counter: cleared on any state change; increments per wait-state cycle with MemReady=0; if MemReady=0 and count==MEM_TIMEOUT−1 → FAULT. MemReady=1 on that same cycle wins (normal transition).
- InstrDone=1 in MEMWB, RWB, ADDI_WB, BRANCH, JUMP, JAL, and in MEMWR when MemReady=1.

## Timing
- Reset: state S_RST, counter 0, every output 0 (State=0) immediately on reset assertion; first FETCH one cycle after reset deasserts.
- Zero-wait latencies (cycles, FETCH to last state inclusive): lw 5, sw 4, R 4, addi 4, beq 3, j 3, jal 3.
- Each MemReady-low cycle adds one cycle. Op sampled only in DECODE and MEMADR.
- Reset mid-instruction or in FAULT: immediate return to S_RST; only reset leaves FAULT.

## Configuration
- CTRL_JAL_EN defined: opcode 000011 → JAL state as above.
- Undefined: JAL state not built; 000011 is illegal → FAULT; Link tied 0.

## Test plan
- Reset then lw, MemReady=1 always → State 1,2,3,4,5,1; MemWB RegWrite=1, MemtoReg=1; InstrDone one pulse.
- sw, MemReady low 3 cycles in MEMWR → MemWrite/IorD held 4 cycles; InstrDone only on MemReady cycle; total 7 cycles.
- FETCH with MemReady low 16 cycles, MEM_TIMEOUT=16 → State=15, Fault=1 after 16th cycle; MemReady high on 16th cycle → DECODE instead.
- Op=111111 in DECODE → FAULT; Fault stays 1 until reset; reset → all outputs 0, State=0.
- beq then j → BRANCH PCWriteCond=1, PCSource=01, ALUOp=01; JUMP PCWrite=1, PCSource=10.
- Op=000011 with CTRL_JAL_EN → State 13, Link=1, RegWrite=1, PCWrite=1; without → FAULT.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: fetch/decode/execute sequencing with memory wait states, timeout and illegal-opcode fault.
// Optional jump-and-link support is built when CTRL_JAL_EN is defined; otherwise opcode 000011 faults.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       Link,
    output logic       InstrDone,
    output logic       Fault,
    output logic [3:0] State
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef CTRL_JAL_EN
    localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic             TO_EN   = (MEM_TIMEOUT != 0);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12,
`ifdef CTRL_JAL_EN
        S_JAL     = 4'd13,
`endif
        S_FAULT   = 4'd15
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_st;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, wait counter and Moore-decoded datapath controls
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_st     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        Link        = 1'b0;
        InstrDone   = 1'b0;
        Fault       = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_d = S_DECODE;
                else          wait_st = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
`ifdef CTRL_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_LW)      state_d = S_MEMRD;
                else if (Op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FAULT;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) state_d = S_MEMWB;
                else          wait_st = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
                if (MemReady) state_d = S_FETCH;
                else          wait_st = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                InstrDone   = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                RegWrite  = 1'b1;
                Link      = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            S_FAULT: Fault = 1'b1;
            default: state_d = S_FAULT;
        endcase

        // Stalled memory: count idle cycles; the last allowed one escalates to FAULT
        if (wait_st) begin
            if (TO_EN && (cnt_q == TO_LIM)) state_d = S_FAULT;
            else if (cnt_q != CNT_MAX)      cnt_d   = cnt_q + CNT_W'(1);
        end
        if (state_d != state_q) cnt_d = '0;
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle State and full control-vector checks.
module tb_multicycle_control_fsm;

    logic       Clock, reset, MemReady;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst, Link, InstrDone, Fault;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_control_fsm dut (
        .Clock(Clock), .reset(reset), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .Link(Link), .InstrDone(InstrDone),
        .Fault(Fault), .State(State)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst,
    //  PCSource,ALUOp,ALUSrcB,Link,InstrDone,Fault}
    logic [18:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, Link, InstrDone, Fault};

    localparam logic [18:0] E_RST    = 19'd0;
    localparam logic [18:0] E_FRDY   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01,1'b0,1'b0,1'b0};
    localparam logic [18:0] E_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01,1'b0,1'b0,1'b0};
    localparam logic [18:0] E_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11,1'b0,1'b0,1'b0};
    localparam logic [18:0] E_MADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0,1'b0};
    localparam logic [18:0] E_MRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [18:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0};
    localparam logic [18:0] E_MWWAIT = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [18:0] E_MWRDY  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0};
    localparam logic [18:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0};
    localparam logic [18:0] E_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0};
    localparam logic [18:0] E_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0};
    localparam logic [18:0] E_BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b01,2'b00,1'b0,1'b1,1'b0};
    localparam logic [18:0] E_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0,1'b1,1'b0};
    localparam logic [18:0] E_JAL    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b00,1'b1,1'b1,1'b0};
    localparam logic [18:0] E_FLT    = 19'd1;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [3:0] es, input logic [18:0] eo);
        checks++;
        assert (State === es) else begin
            errors++;
            $error("FAIL %s State got %0d want %0d", tag, State, es);
        end
        checks++;
        assert (outs === eo) else begin
            errors++;
            $error("FAIL %s outputs got %b want %b", tag, outs, eo);
        end
    endtask

    // Drive inputs just after an edge, check the current state, then advance one cycle
    task automatic cyc(input string tag, input logic mr, input logic [5:0] op,
                       input logic [3:0] es, input logic [18:0] eo);
        MemReady = mr;
        Op       = op;
        #1;
        chk(tag, es, eo);
        @(posedge Clock);
        #1;
    endtask

    task automatic hit_reset(input string tag);
        #2 reset = 1'b1;
        #1 chk(tag, 4'd0, E_RST);
        @(posedge Clock);
        #1 reset = 1'b0;
        cyc({tag, "_exit"}, 1'b1, OP_R, 4'd0, E_RST);
    endtask

    initial begin
        reset    = 1'b1;
        MemReady = 1'b0;
        Op       = OP_R;
        @(posedge Clock);
        #1 chk("por", 4'd0, E_RST);
        reset = 1'b0;
        cyc("rst_exit", 1'b1, OP_LW, 4'd0, E_RST);

        // lw, zero wait
        cyc("lw_f",   1'b1, OP_LW, 4'd1, E_FRDY);
        cyc("lw_d",   1'b1, OP_LW, 4'd2, E_DEC);
        cyc("lw_a",   1'b1, OP_LW, 4'd3, E_MADR);
        cyc("lw_r",   1'b1, OP_LW, 4'd4, E_MRD);
        cyc("lw_wb",  1'b1, OP_LW, 4'd5, E_MWB);

        // sw with three stalled cycles in MEMWR
        cyc("sw_f",   1'b1, OP_SW, 4'd1, E_FRDY);
        cyc("sw_d",   1'b1, OP_SW, 4'd2, E_DEC);
        cyc("sw_a",   1'b1, OP_SW, 4'd3, E_MADR);
        for (int i = 0; i < 3; i++) cyc("sw_wait", 1'b0, OP_SW, 4'd6, E_MWWAIT);
        cyc("sw_done", 1'b1, OP_SW, 4'd6, E_MWRDY);

        // lw with two stalled cycles in MEMRD
        cyc("lw2_f",  1'b1, OP_LW, 4'd1, E_FRDY);
        cyc("lw2_d",  1'b1, OP_LW, 4'd2, E_DEC);
        cyc("lw2_a",  1'b1, OP_LW, 4'd3, E_MADR);
        cyc("lw2_w0", 1'b0, OP_LW, 4'd4, E_MRD);
        cyc("lw2_w1", 1'b0, OP_LW, 4'd4, E_MRD);
        cyc("lw2_r",  1'b1, OP_LW, 4'd4, E_MRD);
        cyc("lw2_wb", 1'b1, OP_LW, 4'd5, E_MWB);

        // R-type, addi, beq, j
        cyc("r_f",    1'b1, OP_R,    4'd1,  E_FRDY);
        cyc("r_d",    1'b1, OP_R,    4'd2,  E_DEC);
        cyc("r_x",    1'b1, OP_R,    4'd7,  E_EXEC);
        cyc("r_wb",   1'b1, OP_R,    4'd8,  E_RWB);
        cyc("ai_f",   1'b1, OP_ADDI, 4'd1,  E_FRDY);
        cyc("ai_d",   1'b1, OP_ADDI, 4'd2,  E_DEC);
        cyc("ai_x",   1'b1, OP_ADDI, 4'd11, E_MADR);
        cyc("ai_wb",  1'b1, OP_ADDI, 4'd12, E_AWB);
        cyc("beq_f",  1'b1, OP_BEQ,  4'd1,  E_FRDY);
        cyc("beq_d",  1'b1, OP_BEQ,  4'd2,  E_DEC);
        cyc("beq_b",  1'b1, OP_BEQ,  4'd9,  E_BR);
        cyc("j_f",    1'b1, OP_J,    4'd1,  E_FRDY);
        cyc("j_d",    1'b1, OP_J,    4'd2,  E_DEC);
        cyc("j_j",    1'b1, OP_J,    4'd10, E_JMP);

        // jal: built only with the macro, illegal otherwise
        cyc("jal_f",  1'b1, OP_JAL, 4'd1, E_FRDY);
        cyc("jal_d",  1'b1, OP_JAL, 4'd2, E_DEC);
`ifdef CTRL_JAL_EN
        cyc("jal_x",  1'b1, OP_JAL, 4'd13, E_JAL);
        cyc("jal_nf", 1'b1, OP_R,   4'd1,  E_FRDY);
`else
        cyc("jal_flt", 1'b1, OP_JAL, 4'd15, E_FLT);
        cyc("jal_stk", 1'b1, OP_R,   4'd15, E_FLT);
`endif
        hit_reset("rst_a");

        // 15 stalled fetch cycles, ready on the 16th: no fault
        for (int i = 0; i < 15; i++) cyc("to_edge_w", 1'b0, OP_R, 4'd1, E_FWAIT);
        cyc("to_edge_rdy", 1'b1, OP_R, 4'd1, E_FRDY);
        cyc("to_edge_d",   1'b1, OP_R, 4'd2, E_DEC);
        cyc("to_edge_x",   1'b1, OP_R, 4'd7, E_EXEC);
        cyc("to_edge_wb",  1'b1, OP_R, 4'd8, E_RWB);

        // 16 stalled fetch cycles: timeout fault, sticky
        for (int i = 0; i < 16; i++) cyc("to_w", 1'b0, OP_R, 4'd1, E_FWAIT);
        cyc("to_flt",  1'b1, OP_R, 4'd15, E_FLT);
        cyc("to_stk",  1'b1, OP_R, 4'd15, E_FLT);
        hit_reset("rst_b");

        // Illegal opcode
        cyc("bad_f",   1'b1, OP_BAD, 4'd1,  E_FRDY);
        cyc("bad_d",   1'b1, OP_BAD, 4'd2,  E_DEC);
        cyc("bad_flt", 1'b0, OP_LW,  4'd15, E_FLT);
        cyc("bad_stk", 1'b1, OP_LW,  4'd15, E_FLT);
        hit_reset("rst_c");

        // Reset in the middle of an instruction
        cyc("mid_f",   1'b1, OP_LW, 4'd1, E_FRDY);
        cyc("mid_d",   1'b1, OP_LW, 4'd2, E_DEC);
        cyc("mid_a",   1'b1, OP_LW, 4'd3, E_MADR);
        MemReady = 1'b0;
        hit_reset("rst_mid");
        cyc("mid_nf",  1'b1, OP_R, 4'd1, E_FRDY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
